regfile_wb_arbiter: RTL and testbench

- Shares the register file's single write port between two writeback requesters: A (EX/ALU result path) and B (MEM/load path).
- Each requester has a one-entry holding buffer with a valid/ready handshake.
- Full buffers are arbitrated round-robin, with an older-first override on same-address conflicts.
- The winner drives registered we/waddr/wdata straight into the regfile write port.
- Also provides a saturating stall counter for performance monitoring.

---
 rtl/regfile_wb_arbiter.sv | 78 +++++++
 tb/tb_regfile_wb_arbiter.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: two-requester writeback buffer and arbiter for the regfile write port
module regfile_wb_arbiter #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_valid,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_data,
  output logic              a_ready,
  input  logic              b_valid,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_data,
  output logic              b_ready,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              rf_src,
  output logic [CNT_W-1:0]  stall_cnt
);
  logic a_full, b_full, a_old, ptr;
  logic [ADDR_W-1:0] a_aq, b_aq;
  logic [DATA_W-1:0] a_dq, b_dq;
  logic grant, a_win, b_win, a_load, b_load, a_stay, b_stay, stall;
  // arbitration over buffered entries; same address defers to the older entry, else round-robin
  always_comb begin
    grant = a_full || b_full;
    b_win = b_full && (!a_full || (a_aq == b_aq ? !a_old : ptr));
    a_win = a_full && !b_win;
    a_ready = rst && (!a_full || a_win);
    b_ready = rst && (!b_full || b_win);
    a_load = a_valid && a_ready && (a_addr != '0);
    b_load = b_valid && b_ready && (b_addr != '0);
    a_stay = a_full && !a_win;
    b_stay = b_full && !b_win;
    stall = (a_valid && !a_ready) || (b_valid && !b_ready);
  end
  // buffer capture, age tracking, pointer update, registered write port and stall counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_full <= 1'b0;
      b_full <= 1'b0;
      a_old <= 1'b0;
      ptr <= 1'b0;
      a_aq <= '0;
      b_aq <= '0;
      a_dq <= '0;
      b_dq <= '0;
      rf_we <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
      rf_src <= 1'b0;
      stall_cnt <= '0;
    end else begin
      a_full <= a_load || a_stay;
      b_full <= b_load || b_stay;
      if (a_load) begin
        a_aq <= a_addr;
        a_dq <= a_data;
      end
      if (b_load) begin
        b_aq <= b_addr;
        b_dq <= b_data;
      end
      a_old <= (a_load && b_load) ? 1'b1 : (a_load && b_stay) ? 1'b0 : (b_load && a_stay) ? 1'b1 : a_old;
      if (a_full && b_full && a_aq != b_aq) ptr <= a_win;
      rf_we <= grant;
      if (grant) begin
        rf_waddr <= b_win ? b_aq : a_aq;
        rf_wdata <= b_win ? b_dq : a_dq;
        rf_src <= b_win;
      end
      if (stall && stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: randomized and directed checks against a queue-based writeback model
module tb_regfile_wb_arbiter;
  logic clk, rst;
  logic a_valid, b_valid;
  logic [4:0] a_addr, b_addr;
  logic [31:0] a_data, b_data;
  logic a_ready, b_ready, rf_we, rf_src;
  logic [4:0] rf_waddr;
  logic [31:0] rf_wdata;
  logic [15:0] stall_cnt;
  logic a_ready4, b_ready4, rf_we4, rf_src4;
  logic [4:0] rf_waddr4;
  logic [31:0] rf_wdata4;
  logic [3:0] stall4;

  regfile_wb_arbiter u_dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(b_ready),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .rf_src(rf_src),
    .stall_cnt(stall_cnt)
  );

  regfile_wb_arbiter #(.CNT_W(4)) u_sat (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready4),
    .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(b_ready4),
    .rf_we(rf_we4), .rf_waddr(rf_waddr4), .rf_wdata(rf_wdata4), .rf_src(rf_src4),
    .stall_cnt(stall4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {logic [4:0] addr; logic [31:0] data;} ent_t;
  typedef struct {bit src; logic [4:0] addr; logic [31:0] data; int t;} wr_t;

  ent_t qa[$], qb[$];
  wr_t wlog[$];
  int pass_n, total_n, cyc_n, seqc, e_stall, gate;
  bit mv[2], mptr, e_we, e_src;
  logic [4:0] ma[2], e_addr;
  logic [31:0] md[2], e_data;
  int ms[2];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total_n++;
    if (act === exp) pass_n++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc_n);
  endtask

  function automatic int mwin();
    if (mv[0] && mv[1]) return (ma[0] == ma[1]) ? (ms[0] < ms[1] ? 0 : 1) : (mptr ? 1 : 0);
    if (mv[0]) return 0;
    if (mv[1]) return 1;
    return -1;
  endfunction

  task automatic model_reset();
    mv[0] = 0; mv[1] = 0; mptr = 0; seqc = 0;
    e_we = 0; e_src = 0; e_addr = '0; e_data = '0; e_stall = 0;
  endtask

  task automatic reset_dut();
    a_valid = 0; b_valid = 0;
    rst = 0;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1;
  endtask

  task automatic cycle();
    bit av, bv, ra, rb;
    ent_t ea, eb;
    int w;
    @(negedge clk);
    av = qa.size() > 0 && ($urandom_range(0, 99) < gate);
    bv = qb.size() > 0 && ($urandom_range(0, 99) < gate);
    ea = av ? qa[0] : '{5'($urandom), $urandom};
    eb = bv ? qb[0] : '{5'($urandom), $urandom};
    a_valid = av; a_addr = ea.addr; a_data = ea.data;
    b_valid = bv; b_addr = eb.addr; b_data = eb.data;
    #1;
    w = mwin();
    ra = rst && (!mv[0] || w == 0);
    rb = rst && (!mv[1] || w == 1);
    check("a_ready", a_ready, ra);
    check("b_ready", b_ready, rb);
    @(posedge clk);
    #1;
    if (rst) begin
      if ((av && !ra) || (bv && !rb)) e_stall++;
      if (w >= 0) begin
        e_we = 1; e_addr = ma[w]; e_data = md[w]; e_src = (w == 1);
        if (mv[0] && mv[1] && ma[0] != ma[1]) mptr = (w == 0);
        mv[w] = 0;
      end else e_we = 0;
      if (av && ra) begin
        void'(qa.pop_front());
        if (ea.addr != 0) begin mv[0] = 1; ma[0] = ea.addr; md[0] = ea.data; ms[0] = seqc++; end
      end
      if (bv && rb) begin
        void'(qb.pop_front());
        if (eb.addr != 0) begin mv[1] = 1; ma[1] = eb.addr; md[1] = eb.data; ms[1] = seqc++; end
      end
    end
    check("rf_we", rf_we, e_we);
    check("rf_waddr", rf_waddr, e_addr);
    check("rf_wdata", rf_wdata, e_data);
    check("rf_src", rf_src, e_src);
    check("stall_cnt", stall_cnt, e_stall > 65535 ? 65535 : e_stall);
    check("stall_cnt4", stall4, e_stall > 15 ? 15 : e_stall);
    if (rf_we) wlog.push_back('{rf_src, rf_waddr, rf_wdata, cyc_n});
    cyc_n++;
  endtask

  initial begin
    int t0, n5;
    pass_n = 0; total_n = 0; cyc_n = 0; gate = 100;
    a_addr = '0; b_addr = '0; a_data = '0; b_data = '0;
    reset_dut();
    rst = 0; #1;
    check("rst_rf_we", rf_we, 0);
    check("rst_rf_waddr", rf_waddr, 0);
    check("rst_rf_wdata", rf_wdata, 0);
    check("rst_rf_src", rf_src, 0);
    check("rst_stall", stall_cnt, 0);
    check("rst_a_ready", a_ready, 0);
    reset_dut();

    // reset mid-flight
    wlog.delete();
    qa.push_back('{5'd5, 32'h11});
    cycle();
    #2 rst = 0;
    model_reset();
    #1;
    check("midrst_rf_we", rf_we, 0);
    check("midrst_a_ready", a_ready, 0);
    check("midrst_stall", stall_cnt, 0);
    qa.delete();
    reset_dut();
    repeat (5) cycle();
    n5 = 0;
    foreach (wlog[i]) if (wlog[i].addr == 5) n5++;
    check("midrst_no_x5_write", n5, 0);

    // single requester stream
    reset_dut();
    wlog.delete();
    for (int i = 1; i <= 4; i++) qa.push_back('{5'(i), 32'hA0 + i});
    t0 = cyc_n;
    repeat (7) cycle();
    check("stream_count", wlog.size(), 4);
    for (int i = 0; i < 4 && i < wlog.size(); i++) begin
      check("stream_addr", wlog[i].addr, i + 1);
      check("stream_data", wlog[i].data, 32'hA1 + i);
      check("stream_src", wlog[i].src, 0);
      check("stream_time", wlog[i].t, t0 + 1 + i);
    end

    // contention, different addresses
    reset_dut();
    wlog.delete();
    qa.push_back('{5'd3, 32'h33});
    qb.push_back('{5'd7, 32'h77});
    for (int i = 0; i < 11; i++) begin
      qa.push_back('{5'(i + 4 + (i >= 3 ? 1 : 0)), 32'h100 + i});
      qb.push_back('{5'(i + 16), 32'h200 + i});
    end
    repeat (28) cycle();
    check("contend_count", wlog.size(), 24);
    for (int i = 0; i < 8 && i < wlog.size(); i++) check("contend_alt", wlog[i].src, i % 2);
    check("contend_first_data", wlog.size() > 0 ? wlog[0].data : 0, 32'h33);
    check("sat_stall4", stall4, 15);

    // same-address ordering
    reset_dut();
    wlog.delete();
    qb.push_back('{5'd9, 32'hBB});
    cycle();
    qa.push_back('{5'd9, 32'hAA});
    repeat (4) cycle();
    qa.push_back('{5'd9, 32'hA9});
    qb.push_back('{5'd9, 32'hB9});
    repeat (5) cycle();
    check("order_count", wlog.size(), 4);
    if (wlog.size() == 4) begin
      check("order0", wlog[0].data, 32'hBB);
      check("order1", wlog[1].data, 32'hAA);
      check("order2", wlog[2].data, 32'hA9);
      check("order3", wlog[3].data, 32'hB9);
    end

    // zero-register drop
    reset_dut();
    wlog.delete();
    qa.push_back('{5'd0, 32'hDEADBEEF});
    qb.push_back('{5'd0, 32'hDEADBEEF});
    repeat (4) cycle();
    check("zero_writes", wlog.size(), 0);
    check("zero_a_consumed", qa.size(), 0);
    check("zero_b_consumed", qb.size(), 0);

    // randomized traffic
    reset_dut();
    gate = 75;
    for (int i = 0; i < 500; i++) begin
      if (qa.size() < 3 && $urandom_range(0, 1)) qa.push_back('{5'($urandom_range(0, 7)), $urandom});
      if (qb.size() < 3 && $urandom_range(0, 1)) qb.push_back('{5'($urandom_range(0, 7)), $urandom});
      cycle();
    end

    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end
endmodule
